// File: rtl/pcie_flr_sequencer.sv
// pcie_flr_sequencer
// Queues PCIe Function Level Reset requests and runs them one at a time:
// hold the targeted function in reset, wait for it to go quiet (or time out),
// then return a single-cycle completion echoing the request.
module pcie_flr_sequencer #(
    parameter int NUM_PF          = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int RST_CYCLES      = 64,
    parameter int QUIESCE_TIMEOUT = 1024
) (
    input  logic              fim_clk,
    input  logic              fim_rst_n,
    input  logic              i_flr_req_tvalid,
    input  logic [2:0]        i_flr_req_pf,
    input  logic [10:0]       i_flr_req_vf,
    input  logic              i_flr_req_vf_active,
    input  logic              i_func_idle,
    output logic              o_func_rst,
    output logic [2:0]        o_func_pf,
    output logic [10:0]       o_func_vf,
    output logic              o_func_vf_active,
    output logic [NUM_PF-1:0] o_pf_flr_rst_n,
    output logic              o_flr_rsp_tvalid,
    output logic [2:0]        o_flr_rsp_pf,
    output logic [10:0]       o_flr_rsp_vf,
    output logic              o_flr_rsp_vf_active,
    output logic              o_ovf_err,
    output logic              o_timeout_err
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int RCW = $clog2(RST_CYCLES) + 1;
    localparam int TCW = $clog2(QUIESCE_TIMEOUT) + 1;

    localparam logic [CW-1:0]  FIFO_FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [RCW-1:0] RST_LAST      = RCW'(RST_CYCLES - 1);
    localparam logic [TCW-1:0] TO_LAST       = TCW'(QUIESCE_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_QUIESCE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    typedef struct packed {
        logic [2:0]  pf;
        logic [10:0] vf;
        logic        vf_active;
    } flr_req_t;

    flr_req_t       fifo_mem [FIFO_DEPTH];
    flr_req_t       req_in;
    flr_req_t       req_reg;
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic [1:0]     state_reg;
    logic [1:0]     state_next;
    logic [RCW-1:0] rst_cnt_reg;
    logic [TCW-1:0] to_cnt_reg;
    logic           ovf_err_reg;
    logic           timeout_err_reg;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;
    logic           push;
    logic           in_assert;
    logic           in_resp;

    // Queue handshake: a pop in the same cycle frees the slot for an incoming request.
    always_comb begin
        req_in.pf        = i_flr_req_pf;
        req_in.vf        = i_flr_req_vf;
        req_in.vf_active = i_flr_req_vf_active;
        fifo_full        = (count_reg == FIFO_FULL_CNT);
        fifo_empty       = (count_reg == '0);
        pop              = (state_reg == ST_IDLE) && !fifo_empty;
        push             = i_flr_req_tvalid && (!fifo_full || pop);
    end

    // Pending-request storage; no reset needed, the pointers define validity.
    always_ff @(posedge fim_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= req_in;
        end
    end

    // Sequencer next-state: one request runs to completion before the next pop.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (pop) state_next = ST_ASSERT;
            ST_ASSERT:  if (rst_cnt_reg == RST_LAST) state_next = ST_QUIESCE;
            ST_QUIESCE: if (i_func_idle || (to_cnt_reg == TO_LAST)) state_next = ST_RESP;
            ST_RESP:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // State, queue pointers, phase counters and sticky error flags.
    always_ff @(posedge fim_clk) begin
        if (!fim_rst_n) begin
            state_reg       <= ST_IDLE;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            req_reg         <= '0;
            rst_cnt_reg     <= '0;
            to_cnt_reg      <= '0;
            ovf_err_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + PW'(1);
                req_reg     <= fifo_mem[rd_ptr_reg];
                rst_cnt_reg <= '0;
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CW'(1);
            end
            if (state_reg == ST_ASSERT) begin
                rst_cnt_reg <= rst_cnt_reg + RCW'(1);
                to_cnt_reg  <= '0;
            end
            if (state_reg == ST_QUIESCE) begin
                to_cnt_reg <= to_cnt_reg + TCW'(1);
                if (!i_func_idle && (to_cnt_reg == TO_LAST)) begin
                    timeout_err_reg <= 1'b1;
                end
            end
            if (i_flr_req_tvalid && fifo_full && !pop) begin
                ovf_err_reg <= 1'b1;
            end
        end
    end

    // Function reset and completion outputs are only non-zero in their own state.
    always_comb begin
        in_assert           = (state_reg == ST_ASSERT);
        in_resp             = (state_reg == ST_RESP);
        o_func_rst          = in_assert;
        o_func_pf           = in_assert ? req_reg.pf : 3'd0;
        o_func_vf           = in_assert ? req_reg.vf : 11'd0;
        o_func_vf_active    = in_assert ? req_reg.vf_active : 1'b0;
        o_flr_rsp_tvalid    = in_resp;
        o_flr_rsp_pf        = in_resp ? req_reg.pf : 3'd0;
        o_flr_rsp_vf        = in_resp ? req_reg.vf : 11'd0;
        o_flr_rsp_vf_active = in_resp ? req_reg.vf_active : 1'b0;
        o_ovf_err           = ovf_err_reg;
        o_timeout_err       = timeout_err_reg;
    end

    // Per-PF reset only for PF-level FLRs; a PF number beyond NUM_PF drives no bit.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PF; gi++) begin : g_pf_rst
            localparam logic [2:0] PF_IDX = 3'(gi);
            assign o_pf_flr_rst_n[gi] = !(in_assert && !req_reg.vf_active && (req_reg.pf == PF_IDX));
        end
    endgenerate

endmodule

// File: tb/tb_pcie_flr_sequencer.sv
// tb_pcie_flr_sequencer
// Directed scenarios plus random traffic, checked every cycle against a
// timestamp-based reference model of the FLR queue and sequence timing.
module tb_pcie_flr_sequencer;

    localparam int NUM_PF = 6;
    localparam int D      = 4;
    localparam int R      = 16;
    localparam int T      = 64;

    typedef struct packed {
        logic [2:0]  pf;
        logic [10:0] vf;
        logic        vfa;
    } req_t;

    logic              fim_clk = 1'b0;
    logic              fim_rst_n;
    logic              i_flr_req_tvalid;
    logic [2:0]        i_flr_req_pf;
    logic [10:0]       i_flr_req_vf;
    logic              i_flr_req_vf_active;
    logic              i_func_idle;
    logic              o_func_rst;
    logic [2:0]        o_func_pf;
    logic [10:0]       o_func_vf;
    logic              o_func_vf_active;
    logic [NUM_PF-1:0] o_pf_flr_rst_n;
    logic              o_flr_rsp_tvalid;
    logic [2:0]        o_flr_rsp_pf;
    logic [10:0]       o_flr_rsp_vf;
    logic              o_flr_rsp_vf_active;
    logic              o_ovf_err;
    logic              o_timeout_err;

    pcie_flr_sequencer #(
        .NUM_PF(NUM_PF), .FIFO_DEPTH(D), .RST_CYCLES(R), .QUIESCE_TIMEOUT(T)
    ) dut (
        .fim_clk(fim_clk), .fim_rst_n(fim_rst_n),
        .i_flr_req_tvalid(i_flr_req_tvalid), .i_flr_req_pf(i_flr_req_pf),
        .i_flr_req_vf(i_flr_req_vf), .i_flr_req_vf_active(i_flr_req_vf_active),
        .i_func_idle(i_func_idle),
        .o_func_rst(o_func_rst), .o_func_pf(o_func_pf), .o_func_vf(o_func_vf),
        .o_func_vf_active(o_func_vf_active), .o_pf_flr_rst_n(o_pf_flr_rst_n),
        .o_flr_rsp_tvalid(o_flr_rsp_tvalid), .o_flr_rsp_pf(o_flr_rsp_pf),
        .o_flr_rsp_vf(o_flr_rsp_vf), .o_flr_rsp_vf_active(o_flr_rsp_vf_active),
        .o_ovf_err(o_ovf_err), .o_timeout_err(o_timeout_err)
    );

    always #5 fim_clk = ~fim_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: pending queue plus timestamps of the running job.
    req_t pend[$];
    req_t cur;
    bit   job_active = 0;
    int   start_c    = 0;
    int   rsp_at     = -1;
    bit   m_ovf      = 0;
    bit   m_to       = 0;
    bit   model_ok   = 0;

    int          rsp_log[$];
    logic [2:0]  last_rsp_pf;
    logic [10:0] last_rsp_vf;
    logic        last_rsp_vfa;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic req_t mk(input int pf, input int vf, input bit vfa);
        req_t r;
        r.pf  = 3'(pf);
        r.vf  = 11'(vf);
        r.vfa = vfa;
        return r;
    endfunction

    function automatic logic [63:0] exp_func();
        logic              on;
        logic [NUM_PF-1:0] mask;
        on   = job_active && (cyc >= start_c) && (cyc < start_c + R);
        mask = '1;
        for (int i = 0; i < NUM_PF; i++)
            if (on && !cur.vfa && int'(cur.pf) == i) mask[i] = 1'b0;
        return 64'({on, on ? cur.pf : 3'd0, on ? cur.vf : 11'd0, on ? cur.vfa : 1'b0, mask});
    endfunction

    function automatic logic [63:0] exp_rsp();
        logic on;
        on = job_active && (rsp_at == cyc);
        return 64'({on, on ? cur.pf : 3'd0, on ? cur.vf : 11'd0, on ? cur.vfa : 1'b0});
    endfunction

    function automatic void model_step(input bit v, input req_t r, input bit idle, input bit rn);
        bit pop;
        bit full;
        if (!rn) begin
            pend.delete();
            job_active = 0;
            rsp_at     = -1;
            m_ovf      = 0;
            m_to       = 0;
            model_ok   = 1;
        end else begin
            pop  = !job_active && (pend.size() > 0);
            full = (pend.size() == D);
            if (job_active) begin
                if (rsp_at == cyc) begin
                    job_active = 0;
                end else if (rsp_at < 0 && cyc >= start_c + R) begin
                    if (idle) begin
                        rsp_at = cyc + 1;
                    end else if (cyc == start_c + R + T - 1) begin
                        rsp_at = cyc + 1;
                        m_to   = 1;
                    end
                end
            end
            if (pop) begin
                cur        = pend.pop_front();
                job_active = 1;
                start_c    = cyc + 1;
                rsp_at     = -1;
            end
            if (v) begin
                if (!full || pop) pend.push_back(r);
                else m_ovf = 1;
            end
        end
        cyc++;
    endfunction

    // One clock: drive at negedge, compare all outputs, log, advance the model.
    task automatic cyc_step(input bit v, input req_t r, input bit idle, input bit rn);
        @(negedge fim_clk);
        fim_rst_n           = rn;
        i_flr_req_tvalid    = v;
        i_flr_req_pf        = r.pf;
        i_flr_req_vf        = r.vf;
        i_flr_req_vf_active = r.vfa;
        i_func_idle         = idle;
        if (model_ok) begin
            check("func_out", 64'({o_func_rst, o_func_pf, o_func_vf, o_func_vf_active, o_pf_flr_rst_n}), exp_func());
            check("rsp_out", 64'({o_flr_rsp_tvalid, o_flr_rsp_pf, o_flr_rsp_vf, o_flr_rsp_vf_active}), exp_rsp());
            check("err_flags", 64'({o_ovf_err, o_timeout_err}), 64'({m_ovf, m_to}));
        end
        if (o_flr_rsp_tvalid === 1'b1) begin
            rsp_log.push_back(cyc);
            last_rsp_pf  = o_flr_rsp_pf;
            last_rsp_vf  = o_flr_rsp_vf;
            last_rsp_vfa = o_flr_rsp_vf_active;
            $display("rsp cycle %0d pf=%0d vf=%0d vf_active=%0d", cyc, o_flr_rsp_pf, o_flr_rsp_vf, o_flr_rsp_vf_active);
        end
        if (v && rn)
            $display("req cycle %0d pf=%0d vf=%0d vf_active=%0d", cyc, r.pf, r.vf, r.vfa);
        model_step(v, r, idle, rn);
    endtask

    task automatic step_idle(input int n);
        for (int i = 0; i < n; i++) cyc_step(0, '0, 1'b1, 1'b1);
    endtask

    // idle_mode: 0 = held low, 1 = held high, 2 = random
    task automatic drain(input int idle_mode, input int max_c);
        int  n;
        bit  idl;
        n = 0;
        while ((job_active || pend.size() > 0) && n < max_c) begin
            idl = (idle_mode == 2) ? ($urandom_range(0, 3) != 0) : (idle_mode == 1);
            cyc_step(0, '0, idl, 1'b1);
            n++;
        end
        step_idle(2);
    endtask

    initial begin
        int n0;
        int t0;
        bit sent;
        int n;

        fim_rst_n           = 1'b0;
        i_flr_req_tvalid    = 1'b0;
        i_flr_req_pf        = '0;
        i_flr_req_vf        = '0;
        i_flr_req_vf_active = 1'b0;
        i_func_idle         = 1'b1;

        // Reset state
        repeat (3) cyc_step(0, '0, 1'b1, 1'b0);
        step_idle(1);
        check("reset_func_rst", 64'(o_func_rst), 64'(0));
        check("reset_pf_rst_n", 64'(o_pf_flr_rst_n), 64'({NUM_PF{1'b1}}));
        check("reset_rsp_valid", 64'(o_flr_rsp_tvalid), 64'(0));

        // PF2 FLR, idle high: reset held R cycles, response at request + R + 3
        n0 = rsp_log.size();
        t0 = cyc;
        cyc_step(1, mk(2, 0, 0), 1'b1, 1'b1);
        step_idle(5);
        check("pf2_pf_rst_n", 64'(o_pf_flr_rst_n), 64'(6'b111011));
        drain(1, 200);
        check("pf2_rsp_count", 64'(rsp_log.size() - n0), 64'(1));
        if (rsp_log.size() > n0) check("pf2_latency", 64'(rsp_log[n0] - t0), 64'(R + 3));
        check("pf2_rsp_pf", 64'(last_rsp_pf), 64'(2));

        // VF FLR pf0 vf5: no PF bit, response echoes the VF
        cyc_step(1, mk(0, 5, 1), 1'b1, 1'b1);
        step_idle(5);
        check("vf_func_vf", 64'({o_func_vf_active, o_func_vf}), 64'({1'b1, 11'd5}));
        check("vf_pf_rst_n", 64'(o_pf_flr_rst_n), 64'({NUM_PF{1'b1}}));
        drain(1, 200);
        check("vf_rsp_vf", 64'({last_rsp_vfa, last_rsp_vf}), 64'({1'b1, 11'd5}));

        // Five back-to-back requests while busy: four kept, fifth dropped
        n0 = rsp_log.size();
        cyc_step(1, mk(1, 1, 0), 1'b1, 1'b1);
        step_idle(3);
        for (int i = 0; i < 5; i++) cyc_step(1, mk(i, 100 + i, i % 2), 1'b1, 1'b1);
        step_idle(1);
        check("burst_ovf", 64'(o_ovf_err), 64'(1));
        drain(1, 400);
        check("burst_rsp_count", 64'(rsp_log.size() - n0), 64'(5));

        // Quiesce timeout with idle held low; the queued request still runs
        cyc_step(0, '0, 1'b0, 1'b0);
        step_idle(1);
        check("to_ovf_cleared", 64'(o_ovf_err), 64'(0));
        n0 = rsp_log.size();
        t0 = cyc;
        cyc_step(1, mk(3, 0, 0), 1'b0, 1'b1);
        cyc_step(1, mk(4, 7, 1), 1'b0, 1'b1);
        drain(0, 400);
        check("to_rsp_count", 64'(rsp_log.size() - n0), 64'(2));
        if (rsp_log.size() > n0) check("to_latency", 64'(rsp_log[n0] - t0), 64'(R + 2 + T));
        check("to_flag", 64'(o_timeout_err), 64'(1));

        // PF number beyond NUM_PF: sequence completes, no PF bit moves
        cyc_step(1, mk(7, 0, 0), 1'b1, 1'b1);
        step_idle(5);
        check("oor_func_rst", 64'(o_func_rst), 64'(1));
        check("oor_pf_rst_n", 64'(o_pf_flr_rst_n), 64'({NUM_PF{1'b1}}));
        drain(1, 200);
        check("oor_rsp_pf", 64'(last_rsp_pf), 64'(7));

        // Request landing on the pop cycle while the queue is full is accepted
        cyc_step(0, '0, 1'b1, 1'b0);
        n0 = rsp_log.size();
        cyc_step(1, mk(1, 11, 0), 1'b1, 1'b1);
        step_idle(2);
        for (int i = 0; i < 4; i++) cyc_step(1, mk(i + 2, 20 + i, 0), 1'b1, 1'b1);
        sent = 0;
        n    = 0;
        while ((job_active || pend.size() > 0) && n < 400) begin
            if (!sent && !job_active && pend.size() == D) begin
                cyc_step(1, mk(5, 9, 0), 1'b1, 1'b1);
                sent = 1;
            end else begin
                cyc_step(0, '0, 1'b1, 1'b1);
            end
            n++;
        end
        step_idle(2);
        check("popfull_ovf", 64'(o_ovf_err), 64'(0));
        check("popfull_rsp_count", 64'(rsp_log.size() - n0), 64'(6));

        // Reset mid-ASSERT with two queued: everything lost, no responses
        n0 = rsp_log.size();
        cyc_step(1, mk(2, 1, 0), 1'b1, 1'b1);
        cyc_step(1, mk(3, 2, 0), 1'b1, 1'b1);
        cyc_step(1, mk(4, 3, 1), 1'b1, 1'b1);
        step_idle(3);
        cyc_step(0, '0, 1'b1, 1'b0);
        step_idle(1);
        check("rst_mid_func_rst", 64'(o_func_rst), 64'(0));
        check("rst_mid_pf_rst_n", 64'(o_pf_flr_rst_n), 64'({NUM_PF{1'b1}}));
        step_idle(100);
        check("rst_mid_no_rsp", 64'(rsp_log.size() - n0), 64'(0));

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            cyc_step($urandom_range(0, 9) == 0,
                     mk($urandom_range(0, 7), $urandom_range(0, 2047), 1'($urandom_range(0, 1))),
                     $urandom_range(0, 3) != 0, 1'b1);
        end
        drain(2, 2000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
